wb_arbiter2: RTL and testbench
==============================

// Module: wb_arbiter2
// PURPOSE
//   Two-master, one-slave pipelined Wishbone arbiter. Shares one slave peripheral
//   (e.g. LED sequencer, single-transaction busy slave) between two bus masters.
//   Grant is held for a master's whole cyc; round-robin selection between
//   contenders; per-grant outstanding-transaction tracking with local stall.
// PARAMETERS
//   AW       32  address width
//   DW       32  data width
//   MAX_OUT  1   max accepted-but-unacked slave transactions (>=1)
//   TIMEOUT  16  ack-wait limit in cycles; used only with WB_ARB_TIMEOUT_EN
// PORTS
//   clk        in   1   clock
//   rst        in   1   reset
//   mN_cyc     in   1   master N cycle (N = 0,1; same set per master)
//   mN_stb     in   1   master N strobe
//   mN_we      in   1   master N write enable
//   mN_addr    in   AW  master N address
//   mN_data_w  in   DW  master N write data
//   mN_data_r  out  DW  master N read data
//   mN_ack     out  1   master N ack
//   mN_stall   out  1   master N stall
//   mN_err     out  1   master N timeout error
//   s_cyc/s_stb/s_we  out 1   slave controls
//   s_addr     out  AW  slave address
//   s_data_w   out  DW  slave write data
//   s_data_r   in   DW  slave read data
//   s_ack      in   1   slave ack
//   s_stall    in   1   slave stall
//   grant      out  2   one-hot status: 01=m0, 10=m1, 00=idle
// BEHAVIOUR
// - Reset rst, synchronous, active-high; clock clk. Reset state: IDLE, last=m1.
//   Outstanding cnt 0, timer 0; all outputs 0 except mN_stall = mN_cyc.
// - States IDLE, G0, G1 (registered). grant decoded from state.
// - IDLE: s_cyc=s_stb=s_we=0; s_addr/s_data_w=0; masters get ack=0, data_r=0.
//   Each master sees stall=mN_cyc.
//   Only one cyc high -> that master's G at next edge.
//   Both high -> master != last wins; last updated on grant.
//   Latency: cyc at edge t -> grant and s_cyc visible after edge t+1.
// - Gx: slave signals = master x's (comb); mx_ack=s_ack, mx_data_r=s_data_r.
//   mx_stall = s_stall | (cnt==MAX_OUT && !s_ack).
//   Other master: ack=0, data_r=0, stall=its cyc.
// - cnt: +1 on s_stb&&!s_stall&&!local stall, -1 on s_ack; both same cycle ->
//   unchanged. Never exceeds MAX_OUT, never wraps below 0.
// - Gx -> IDLE at edge where mx_cyc==0; one dead IDLE cycle before any regrant.
//   cnt cleared on release (masters must not drop cyc with outstanding txns).
// - s_ack while IDLE is ignored; cnt stays 0.
// - rst mid-grant: IDLE at next edge, slave cyc drops, outstanding txns abandoned.
// CONFIGURATION
// - WB_ARB_TIMEOUT_EN defined: in Gx, timer counts cycles with cnt>0 && !s_ack.
//   Timer clears on s_ack or cnt==0. On count TIMEOUT: mx_err=1 for exactly
//   one cycle, mx_ack=0, s_cyc=s_stb=0 that cycle, then IDLE at next edge,
//   cnt=0. last=x.
// - Undefined: mN_err tied 0, no timer logic, TIMEOUT ignored.
//   Grant held until master drops cyc.
// TESTING
// 1. Only m0: cyc/stb/we, addr 0, data 1; slave ack 1 cycle after accept ->
//    grant=01 one cycle after cyc; m0_ack one pulse; m1_ack=0; cnt returns 0.
// 2. m0,m1 raise cyc same cycle post-reset -> m0 granted, m1_stall=1
//    throughout; m0 drops cyc -> grant=00 for 1 cycle, then grant=10.
// 3. Both hold cyc permanently, each drops cyc for 1 cycle after its ack ->
//    grant alternates 01,00,10,00,01.
// 4. MAX_OUT=1, m0 stb 2 cycles back-to-back, s_stall=0, ack at cycle 3 ->
//    second stb stalled locally until ack; s_stb accepted exactly twice.
// 5. rst asserted while grant=10 with cnt=1 -> next cycle grant=00, s_cyc=0,
//    m1_ack=0, cnt=0.
// 6. WB_ARB_TIMEOUT_EN, TIMEOUT=8, slave never acks -> m0_err exactly 1 cycle,
//    8 cycles after accept; grant=00 next. Without macro: grant stays 01.

Source files
------------

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master round-robin pipelined Wishbone arbiter
// Optional ack-wait timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 1,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_data_w,
    output logic [DW-1:0] m0_data_r,
    output logic          m0_ack,
    output logic          m0_stall,
    output logic          m0_err,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_data_w,
    output logic [DW-1:0] m1_data_r,
    output logic          m1_ack,
    output logic          m1_stall,
    output logic          m1_err,
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_data_w,
    input  logic [DW-1:0] s_data_r,
    input  logic          s_ack,
    input  logic          s_stall,
    output logic [1:0]    grant
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_G0   = 2'd1;
    localparam logic [1:0] S_G1   = 2'd2;

    localparam int CW = (MAX_OUT < 2) ? 1 : $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          sel0, sel1, granted;
    logic          g_cyc, g_stb, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data_w;
    logic          local_stall, timeout_hit, accept, retire;

    assign sel0    = (state_q == S_G0);
    assign sel1    = (state_q == S_G1);
    assign granted = sel0 | sel1;
    assign grant   = {sel1, sel0};

    assign g_cyc    = sel1 ? m1_cyc    : m0_cyc;
    assign g_stb    = sel1 ? m1_stb    : m0_stb;
    assign g_we     = sel1 ? m1_we     : m0_we;
    assign g_addr   = sel1 ? m1_addr   : m0_addr;
    assign g_data_w = sel1 ? m1_data_w : m0_data_w;

    // A full pipeline frees a slot in the same cycle the slave acks.
    assign local_stall = granted && (cnt_q == CNT_MAX) && !s_ack;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          waiting;

    assign waiting     = granted && g_cyc && (cnt_q != '0) && !s_ack;
    assign timeout_hit = waiting && (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        timer_d = '0;
        if (waiting && !timeout_hit)
            timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            timer_q <= '0;
        else
            timer_q <= timer_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        s_cyc     = granted & g_cyc & ~timeout_hit;
        s_stb     = granted & g_cyc & g_stb & ~local_stall & ~timeout_hit;
        s_we      = granted & g_we;
        s_addr    = granted ? g_addr   : '0;
        s_data_w  = granted ? g_data_w : '0;
        m0_ack    = sel0 & s_ack & ~timeout_hit;
        m1_ack    = sel1 & s_ack & ~timeout_hit;
        m0_data_r = sel0 ? s_data_r : '0;
        m1_data_r = sel1 ? s_data_r : '0;
        m0_stall  = sel0 ? (s_stall | local_stall) : m0_cyc;
        m1_stall  = sel1 ? (s_stall | local_stall) : m1_cyc;
        m0_err    = sel0 & timeout_hit;
        m1_err    = sel1 & timeout_hit;
    end

    assign accept = s_stb && !s_stall;
    assign retire = granted && s_ack && (cnt_q != '0);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (m0_cyc && m1_cyc) begin
                    state_d = last_q ? S_G0 : S_G1;
                    last_d  = ~last_q;
                end else if (m0_cyc) begin
                    state_d = S_G0;
                    last_d  = 1'b0;
                end else if (m1_cyc) begin
                    state_d = S_G1;
                    last_d  = 1'b1;
                end
            end
            S_G0, S_G1: begin
                if (!g_cyc || timeout_hit) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (timeout_hit)
                        last_d = sel1;
                end else if (accept && !retire) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (retire && !accept) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - directed-vector bench for wb_arbiter2
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_addr, m0_data_w, m1_addr, m1_data_w;
    logic [31:0] m0_data_r, m1_data_r;
    logic        m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err;
    logic        s_cyc, s_stb, s_we, s_ack, s_stall;
    logic [31:0] s_addr, s_data_w, s_data_r;
    logic [1:0]  grant;

    int vectors = 0;
    int miscompares = 0;
    int acc_cnt = 0;
    logic acc_clr = 1'b0;
    logic to_en;

    always #5 clk = ~clk;

    wb_arbiter2 #(.AW(32), .DW(32), .MAX_OUT(1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_data_w(m0_data_w), .m0_data_r(m0_data_r), .m0_ack(m0_ack),
        .m0_stall(m0_stall), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_data_w(m1_data_w), .m1_data_r(m1_data_r), .m1_ack(m1_ack),
        .m1_stall(m1_stall), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr),
        .s_data_w(s_data_w), .s_data_r(s_data_r), .s_ack(s_ack),
        .s_stall(s_stall), .grant(grant)
    );

    always @(posedge clk) begin
        if (acc_clr)
            acc_cnt <= 0;
        else if (s_cyc && s_stb && !s_stall)
            acc_cnt <= acc_cnt + 1;
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef WB_ARB_TIMEOUT_EN
        to_en = 1'b1;
`else
        to_en = 1'b0;
`endif
        rst = 1'b1;
        {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
        {m0_addr, m0_data_w, m1_addr, m1_data_w, s_data_r} = '0;
        {s_ack, s_stall} = '0;

        // reset state
        tick(); tick();
        check_vec("rst_grant", grant, 0);
        check_vec("rst_scyc", s_cyc, 0);
        check_vec("rst_m0stall", m0_stall, 0);
        check_vec("rst_m0err", m0_err, 0);
        m0_cyc = 1'b1; #1;
        check_vec("rst_m0stall_cyc", m0_stall, 1);
        check_vec("rst_hold_grant", grant, 0);

        // single master transaction
        rst = 1'b0; m0_stb = 1'b1; m0_we = 1'b1; m0_addr = 0; m0_data_w = 1; #1;
        check_vec("t1_idle_grant", grant, 0);
        check_vec("t1_idle_stall", m0_stall, 1);
        tick();
        check_vec("t1_grant", grant, 2'b01);
        check_vec("t1_scyc", s_cyc, 1);
        check_vec("t1_sstb", s_stb, 1);
        check_vec("t1_swe", s_we, 1);
        check_vec("t1_sdataw", s_data_w, 1);
        check_vec("t1_m0stall", m0_stall, 0);
        tick();
        m0_stb = 1'b0; s_ack = 1'b1; s_data_r = 32'hA5; #1;
        check_vec("t1_m0ack", m0_ack, 1);
        check_vec("t1_m0datar", m0_data_r, 32'hA5);
        check_vec("t1_m1ack", m1_ack, 0);
        check_vec("t1_m1datar", m1_data_r, 0);
        tick();
        s_ack = 1'b0; #1;
        check_vec("t1_m0ack_done", m0_ack, 0);
        m0_stb = 1'b1; #1;
        check_vec("t1_cnt_zero", m0_stall, 0);
        m0_stb = 1'b0; m0_we = 1'b0; m0_cyc = 1'b0;
        tick();
        check_vec("t1_release", grant, 0);

        // simultaneous request after reset: m0 first, dead cycle, then m1
        rst = 1'b1; tick(); rst = 1'b0;
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        tick();
        check_vec("t2_grant_m0", grant, 2'b01);
        check_vec("t2_m1stall_a", m1_stall, 1);
        check_vec("t2_m1ack", m1_ack, 0);
        tick();
        check_vec("t2_m1stall_b", m1_stall, 1);
        m0_cyc = 1'b0;
        tick();
        check_vec("t2_dead", grant, 0);
        check_vec("t2_m1stall_c", m1_stall, 1);
        tick();
        check_vec("t2_grant_m1", grant, 2'b10);
        check_vec("t2_m1stall_d", m1_stall, 0);

        // round robin with persistent requests
        m0_cyc = 1'b1; m1_cyc = 1'b0;
        tick();
        check_vec("t3_a", grant, 0);
        m1_cyc = 1'b1;
        tick();
        check_vec("t3_b", grant, 2'b01);
        m0_cyc = 1'b0;
        tick();
        check_vec("t3_c", grant, 0);
        m0_cyc = 1'b1;
        tick();
        check_vec("t3_d", grant, 2'b10);
        m1_cyc = 1'b0;
        tick();
        check_vec("t3_e", grant, 0);
        m1_cyc = 1'b1;
        tick();
        check_vec("t3_f", grant, 2'b01);

        // MAX_OUT=1 local stall on back-to-back strobes
        rst = 1'b1; m1_cyc = 1'b0; tick();
        rst = 1'b0; acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0; m0_stb = 1'b1; m0_addr = 4; #1;
        check_vec("t4_first_stall", m0_stall, 0);
        check_vec("t4_first_sstb", s_stb, 1);
        tick();
        m0_addr = 8; #1;
        check_vec("t4_local_stall", m0_stall, 1);
        check_vec("t4_sstb_gated", s_stb, 0);
        tick();
        s_ack = 1'b1; #1;
        check_vec("t4_ack_unstall", m0_stall, 0);
        check_vec("t4_second_sstb", s_stb, 1);
        check_vec("t4_ack1", m0_ack, 1);
        tick();
        m0_stb = 1'b0; s_ack = 1'b0; #1;
        check_vec("t4_accepts", acc_cnt, 2);
        check_vec("t4_cnt_full", m0_stall, 1);
        s_ack = 1'b1; #1;
        check_vec("t4_ack2", m0_ack, 1);
        tick();
        s_ack = 1'b0; #1;
        check_vec("t4_cnt_empty", m0_stall, 0);
        check_vec("t4_accepts_end", acc_cnt, 2);
        m0_cyc = 1'b0;
        tick();

        // reset in the middle of an m1 grant
        rst = 1'b1; m1_cyc = 1'b1; tick();
        rst = 1'b0; m1_stb = 1'b1;
        tick();
        check_vec("t5_grant", grant, 2'b10);
        tick();
        m1_stb = 1'b0; #1;
        check_vec("t5_outstanding", m1_stall, 1);
        rst = 1'b1; s_ack = 1'b1;
        tick();
        check_vec("t5_rst_grant", grant, 0);
        check_vec("t5_rst_scyc", s_cyc, 0);
        check_vec("t5_rst_m1ack", m1_ack, 0);
        rst = 1'b0; s_ack = 1'b0;
        tick();
        check_vec("t5_regrant", grant, 2'b10);
        check_vec("t5_cnt_clear", m1_stall, 0);
        m1_cyc = 1'b0;
        tick();

        // slave never acks
        rst = 1'b1; tick();
        rst = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        check_vec("t6_grant", grant, 2'b01);
        tick();
        m0_stb = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            check_vec($sformatf("t6_err_%0d", k), m0_err, (to_en && k == 8) ? 1 : 0);
            check_vec($sformatf("t6_scyc_%0d", k), s_cyc, (to_en && k == 8) ? 0 : 1);
            tick();
        end
        check_vec("t6_after_grant", grant, to_en ? 2'b00 : 2'b01);
        check_vec("t6_after_err", m0_err, 0);
        m0_cyc = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
